input_unit_vc: RTL and testbench
================================

# input_unit_vc

Parametrised router input unit with NUM_VCS virtual channels. Each VC has a BUF_DEPTH flit FIFO and its own packet state machine (IDLE/ROUTING/WAITING/ACTIVE). The unit computes an XY route per packet, requests an output VC and then switch traversal per flit, and returns one credit upstream per flit it forwards. It sits between the link receiver and the router's VC/switch allocators.

## Interface
- FLIT_W, 34: flit width; bits [FLIT_W-1:FLIT_W-2] are the type: 2'b10 HEAD, 2'b00 BODY, 2'b01 TAIL, 2'b11 HEAD_TAIL.
- COORD_W, 4: coordinate width; head dest_x = flit[COORD_W-1:0], dest_y = flit[2*COORD_W-1:COORD_W].
- NUM_VCS, 2: virtual channels (>=1); VC_W = max(1, clog2(NUM_VCS)).
- BUF_DEPTH, 4: flits per VC FIFO (power of two, >=2).
- MY_X / MY_Y, 0 / 0: this router's coordinates.
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_flit_valid  in  1  flit present on input link.
- i_flit  in  FLIT_W  incoming flit.
- i_flit_vc  in  VC_W  target VC of incoming flit.
- o_credit_valid  out  1  one credit returned upstream.
- o_credit_vc  out  VC_W  VC of returned credit.
- o_vc_req  out  NUM_VCS  per-VC output-VC allocation request.
- i_vc_ack  in  NUM_VCS  per-VC VC-allocation grant.
- o_switch_req  out  NUM_VCS  per-VC switch request.
- i_switch_ack  in  NUM_VCS  switch grant, at most one bit high.
- o_route  out  5*NUM_VCS  one-hot route per VC; bit0 LOCAL, 1 NORTH, 2 EAST, 3 SOUTH, 4 WEST.
- o_flit_valid  out  1  forwarded flit valid.
- o_flit  out  FLIT_W  forwarded flit.
- o_flit_vc  out  VC_W  VC the forwarded flit came from.
- o_error  out  1  sticky protocol error.

## Operation
- Write: i_flit_valid pushes i_flit into FIFO[i_flit_vc]. The push is accepted if count < BUF_DEPTH, or if the same VC pops in the same cycle.
- Overflow: a push into a full VC with no same-cycle pop is dropped.
- Pointers wrap modulo BUF_DEPTH; count is clog2(BUF_DEPTH)+1 bits wide.
- Per-VC FSM transitions:
  - IDLE -> ROUTING when the FIFO is non-empty and the front flit is HEAD or HEAD_TAIL.
  - ROUTING: registers the XY route from the front head and goes to WAITING unconditionally.
  - XY route: dest_x > MY_X gives EAST; dest_x < MY_X gives WEST; otherwise dest_y > MY_Y gives NORTH, dest_y < MY_Y gives SOUTH, else LOCAL. Comparisons are unsigned.
  - WAITING: o_vc_req[v]=1; goes to ACTIVE on i_vc_ack[v].
  - ACTIVE: o_switch_req[v] = FIFO non-empty. On i_switch_ack[v], pop the front flit. If it was TAIL or HEAD_TAIL, go to IDLE.
- o_route[v] holds its value from ROUTING exit until IDLE entry, and is 0 in IDLE/ROUTING.
- Every pop produces o_flit_valid and o_credit_valid for that VC on the next cycle.
- i_switch_ack[v] outside ACTIVE, or while the FIFO is empty: ignored.
- Multiple i_switch_ack bits high: lowest index honoured; with the macro, o_error is set.

## Timing
- Reset: all FSMs IDLE, FIFOs empty. All outputs 0: o_route, o_vc_req, o_switch_req, o_flit_valid, o_flit, o_flit_vc, o_credit_valid, o_credit_vc, o_error.
- Reset mid-packet discards all buffered flits and returns no credits.
- No bypass: a flit written at cycle t is visible at the FIFO front at t+1.
- Minimum head latency, written at t with acks returned immediately: ROUTING t+2, WAITING t+3, ACTIVE t+4, switch ack t+4, o_flit_valid t+5.
- Body flits: one per cycle while switch acks are granted back to back.
- o_credit_* and o_flit_* are registered and stay aligned on the same cycle.

## Configuration
- Macro INPUT_UNIT_PROTOCOL_CHECK_EN.
- Defined:
  - o_error is set sticky, until reset, on: overflow, a BODY/TAIL flit at the front in IDLE, or a multi-hot i_switch_ack.
  - A BODY/TAIL flit at the front in IDLE is popped and discarded, and its credit is returned.
- Undefined:
  - o_error is tied to 0.
  - A BODY/TAIL flit at the front in IDLE stalls that VC. No recovery except reset.

## Test plan
- Single HEAD_TAIL on VC0, dest (0,0), MY=(0,0), acks immediate -> o_route[4:0]=5'b00001; o_flit_valid at t+5; o_credit_valid with vc 0 in the same cycle; FSM back in IDLE.
- 4-flit packet on VC1, dest_x=3 > MY_X=1, acks held high -> route EAST (5'b00100); 4 consecutive o_flit_valid cycles; 4 credits for vc 1.
- Interleaved packets on VC0 and VC1, i_switch_ack alternating between them -> each VC forwards its flits in FIFO order with correct o_flit_vc.
- i_vc_ack held low for 10 cycles -> VC stays in WAITING with o_vc_req=1 and o_switch_req=0; after ack it reaches ACTIVE the next cycle.
- Fill VC0 to BUF_DEPTH=4, push a 5th flit with no pop -> flit dropped; o_error=1 only when INPUT_UNIT_PROTOCOL_CHECK_EN is defined. Then push while popping on a full FIFO -> push accepted.
- Assert reset mid-packet with 2 flits buffered -> next cycle all outputs 0, FIFOs empty, no credits issued.

Source files
------------

// File: rtl/input_unit_vc.sv
// input_unit_vc: router input unit with one flit FIFO and one packet FSM per
// virtual channel. Heads are XY-routed, then each VC requests an output VC and
// switch traversal per flit; every forwarded flit returns one credit upstream.
// Define INPUT_UNIT_PROTOCOL_CHECK_EN to enable the sticky o_error flag and the
// discarding of stray BODY/TAIL flits found at the front of an idle VC.
module input_unit_vc #(
  parameter int FLIT_W    = 34,
  parameter int COORD_W   = 4,
  parameter int NUM_VCS   = 2,
  parameter int BUF_DEPTH = 4,
  parameter int MY_X      = 0,
  parameter int MY_Y      = 0,
  localparam int VC_W     = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_flit_valid,
  input  logic [FLIT_W-1:0]    i_flit,
  input  logic [VC_W-1:0]      i_flit_vc,
  output logic                 o_credit_valid,
  output logic [VC_W-1:0]      o_credit_vc,
  output logic [NUM_VCS-1:0]   o_vc_req,
  input  logic [NUM_VCS-1:0]   i_vc_ack,
  output logic [NUM_VCS-1:0]   o_switch_req,
  input  logic [NUM_VCS-1:0]   i_switch_ack,
  output logic [5*NUM_VCS-1:0] o_route,
  output logic                 o_flit_valid,
  output logic [FLIT_W-1:0]    o_flit,
  output logic [VC_W-1:0]      o_flit_vc,
  output logic                 o_error
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ROUTING, S_WAITING, S_ACTIVE} vcState_t;

  logic [FLIT_W-1:0]  r_buf   [NUM_VCS][BUF_DEPTH];
  logic [PTR_W-1:0]   r_wrPtr [NUM_VCS];
  logic [PTR_W-1:0]   r_rdPtr [NUM_VCS];
  logic [CNT_W-1:0]   r_count [NUM_VCS];
  vcState_t           r_state [NUM_VCS];
  logic [4:0]         r_route [NUM_VCS];
  logic               r_flitValid;
  logic [FLIT_W-1:0]  r_flit;
  logic [VC_W-1:0]    r_flitVc;
  logic               r_creditValid;
  logic [VC_W-1:0]    r_creditVc;

  logic [FLIT_W-1:0]  w_front [NUM_VCS];
  logic [NUM_VCS-1:0] w_notEmpty;
  logic [NUM_VCS-1:0] w_frontIsHead;
  logic [NUM_VCS-1:0] w_frontEndsPkt;
  logic [NUM_VCS-1:0] w_ackSel;
  logic [NUM_VCS-1:0] w_pop;
  logic [NUM_VCS-1:0] w_discard;
  logic [NUM_VCS-1:0] w_deq;
  logic [NUM_VCS-1:0] w_push;
  logic               w_anyPop;
  logic [VC_W-1:0]    w_popVc;
  logic [FLIT_W-1:0]  w_popFlit;
  logic [VC_W-1:0]    w_deqVc;

  // XY routing: resolve X first, then Y, unsigned compares against our position
  function automatic logic [4:0] xyRoute(input logic [2*COORD_W-1:0] dest);
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    dx = dest[COORD_W-1:0];
    dy = dest[2*COORD_W-1:COORD_W];
    if (dx > COORD_W'(MY_X))      xyRoute = 5'b00100;
    else if (dx < COORD_W'(MY_X)) xyRoute = 5'b10000;
    else if (dy > COORD_W'(MY_Y)) xyRoute = 5'b00010;
    else if (dy < COORD_W'(MY_Y)) xyRoute = 5'b01000;
    else                          xyRoute = 5'b00001;
  endfunction

  // Decode the flit sitting at the front of each VC FIFO
  always_comb begin
    for (int v = 0; v < NUM_VCS; v++) begin
      w_front[v]        = r_buf[v][r_rdPtr[v]];
      w_notEmpty[v]     = (r_count[v] != '0);
      w_frontIsHead[v]  = r_buf[v][r_rdPtr[v]][FLIT_W-1];
      w_frontEndsPkt[v] = r_buf[v][r_rdPtr[v]][FLIT_W-2];
    end
  end

  // When several switch grants arrive together only the lowest index is honoured
  assign w_ackSel = i_switch_ack & (~i_switch_ack + NUM_VCS'(1));

  // A granted VC pops only while ACTIVE and holding a flit
  always_comb begin
    w_pop     = '0;
    w_anyPop  = 1'b0;
    w_popVc   = '0;
    w_popFlit = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      if (w_ackSel[v] && (r_state[v] == S_ACTIVE) && w_notEmpty[v]) begin
        w_pop[v]  = 1'b1;
        w_anyPop  = 1'b1;
        w_popVc   = VC_W'(v);
        w_popFlit = w_front[v];
      end
    end
  end

`ifdef INPUT_UNIT_PROTOCOL_CHECK_EN
  logic r_error;
  logic w_overflow;
  logic w_stray;
  logic w_multiAck;

  // Drop one stray BODY/TAIL from an idle VC when no switch pop needs the credit port
  always_comb begin
    logic found;
    found     = 1'b0;
    w_discard = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      if (!found && !w_anyPop && (r_state[v] == S_IDLE) && w_notEmpty[v] && !w_frontIsHead[v]) begin
        w_discard[v] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  // Detect the protocol violations that set the sticky error flag
  always_comb begin
    w_overflow = 1'b0;
    w_stray    = 1'b0;
    for (int v = 0; v < NUM_VCS; v++) begin
      if (i_flit_valid && (i_flit_vc == VC_W'(v)) && (r_count[v] == CNT_W'(BUF_DEPTH)) && !w_deq[v])
        w_overflow = 1'b1;
      if ((r_state[v] == S_IDLE) && w_notEmpty[v] && !w_frontIsHead[v])
        w_stray = 1'b1;
    end
    w_multiAck = |(i_switch_ack & (i_switch_ack - NUM_VCS'(1)));
  end

  // Hold the error flag until reset
  always_ff @(posedge clk) begin
    if (reset) r_error <= 1'b0;
    else       r_error <= r_error | w_overflow | w_stray | w_multiAck;
  end

  assign o_error = r_error;
`else
  assign w_discard = '0;
  assign o_error   = 1'b0;
`endif

  assign w_deq = w_pop | w_discard;

  // Accept a push if there is room, or if the same VC frees a slot this cycle
  always_comb begin
    w_push  = '0;
    w_deqVc = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      if (i_flit_valid && (i_flit_vc == VC_W'(v)) && ((r_count[v] < CNT_W'(BUF_DEPTH)) || w_deq[v]))
        w_push[v] = 1'b1;
      if (w_deq[v])
        w_deqVc = VC_W'(v);
    end
  end

  // Store accepted flits; storage needs no reset since occupancy gates reads
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VCS; v++) begin
      if (w_push[v]) r_buf[v][r_wrPtr[v]] <= i_flit;
    end
  end

  // Advance FIFO pointers and occupancy; reset empties every VC
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        r_wrPtr[v] <= '0;
        r_rdPtr[v] <= '0;
        r_count[v] <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        if (w_push[v]) r_wrPtr[v] <= r_wrPtr[v] + PTR_W'(1);
        if (w_deq[v])  r_rdPtr[v] <= r_rdPtr[v] + PTR_W'(1);
        r_count[v] <= r_count[v] + CNT_W'(w_push[v]) - CNT_W'(w_deq[v]);
      end
    end
  end

  // Per-VC packet FSM; the route is held from ROUTING exit until back in IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        r_state[v] <= S_IDLE;
        r_route[v] <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        case (r_state[v])
          S_IDLE: begin
            if (w_notEmpty[v] && w_frontIsHead[v]) r_state[v] <= S_ROUTING;
          end
          S_ROUTING: begin
            r_route[v] <= xyRoute(w_front[v][2*COORD_W-1:0]);
            r_state[v] <= S_WAITING;
          end
          S_WAITING: begin
            if (i_vc_ack[v]) r_state[v] <= S_ACTIVE;
          end
          S_ACTIVE: begin
            if (w_pop[v] && w_frontEndsPkt[v]) begin
              r_state[v] <= S_IDLE;
              r_route[v] <= '0;
            end
          end
          default: r_state[v] <= S_IDLE;
        endcase
      end
    end
  end

  // Register the forwarded flit together with its upstream credit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flitValid   <= 1'b0;
      r_flit        <= '0;
      r_flitVc      <= '0;
      r_creditValid <= 1'b0;
      r_creditVc    <= '0;
    end else begin
      r_flitValid   <= w_anyPop;
      r_flit        <= w_anyPop ? w_popFlit : '0;
      r_flitVc      <= w_anyPop ? w_popVc : '0;
      r_creditValid <= |w_deq;
      r_creditVc    <= w_deqVc;
    end
  end

  // Allocator requests decode straight from registered state and occupancy
  always_comb begin
    o_vc_req     = '0;
    o_switch_req = '0;
    o_route      = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      o_vc_req[v]        = (r_state[v] == S_WAITING);
      o_switch_req[v]    = (r_state[v] == S_ACTIVE) && w_notEmpty[v];
      o_route[5*v +: 5]  = r_route[v];
    end
  end

  assign o_flit_valid   = r_flitValid;
  assign o_flit         = r_flit;
  assign o_flit_vc      = r_flitVc;
  assign o_credit_valid = r_creditValid;
  assign o_credit_vc    = r_creditVc;

endmodule

// File: tb/tb_input_unit_vc.sv
// tb_input_unit_vc: directed stimulus with a scoreboard for input_unit_vc.
// The DUT runs at MY=(1,1) so every XY direction is reachable.
// Error expectations follow INPUT_UNIT_PROTOCOL_CHECK_EN.
module tb_input_unit_vc;

  localparam int FLIT_W = 34;
  localparam logic [1:0] HEAD = 2'b10;
  localparam logic [1:0] BODY = 2'b00;
  localparam logic [1:0] TAIL = 2'b01;
  localparam logic [1:0] HT   = 2'b11;
`ifdef INPUT_UNIT_PROTOCOL_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              i_flit_valid;
  logic [FLIT_W-1:0] i_flit;
  logic              i_flit_vc;
  logic              o_credit_valid;
  logic              o_credit_vc;
  logic [1:0]        o_vc_req;
  logic [1:0]        i_vc_ack;
  logic [1:0]        o_switch_req;
  logic [1:0]        i_switch_ack;
  logic [9:0]        o_route;
  logic              o_flit_valid;
  logic [FLIT_W-1:0] o_flit;
  logic              o_flit_vc;
  logic              o_error;

  int checks   = 0;
  int failures = 0;
  int credits1 = 0;
  bit monEn    = 1'b0;
  logic [FLIT_W-1:0] expQ0[$];
  logic [FLIT_W-1:0] expQ1[$];

  always #5 clk = ~clk;

  input_unit_vc #(
    .FLIT_W(34), .COORD_W(4), .NUM_VCS(2), .BUF_DEPTH(4), .MY_X(1), .MY_Y(1)
  ) dut (
    .clk(clk), .reset(reset),
    .i_flit_valid(i_flit_valid), .i_flit(i_flit), .i_flit_vc(i_flit_vc),
    .o_credit_valid(o_credit_valid), .o_credit_vc(o_credit_vc),
    .o_vc_req(o_vc_req), .i_vc_ack(i_vc_ack),
    .o_switch_req(o_switch_req), .i_switch_ack(i_switch_ack),
    .o_route(o_route),
    .o_flit_valid(o_flit_valid), .o_flit(o_flit), .o_flit_vc(o_flit_vc),
    .o_error(o_error)
  );

  function automatic logic [FLIT_W-1:0] mkFlit(input logic [1:0] t, input logic [23:0] p,
                                               input logic [3:0] dx, input logic [3:0] dy);
    return {t, p, dy, dx};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one flit for the current cycle and record it if it should come out
  task automatic applyStimulus(input logic vc, input logic [FLIT_W-1:0] f, input bit expectOut);
    i_flit_valid = 1'b1;
    i_flit       = f;
    i_flit_vc    = vc;
    if (expectOut) begin
      if (vc == 1'b0) expQ0.push_back(f);
      else            expQ1.push_back(f);
    end
  endtask

  task automatic idleLink();
    i_flit_valid = 1'b0;
    i_flit       = '0;
    i_flit_vc    = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n;
    n = 0;
    while ((expQ0.size() + expQ1.size()) != 0 && n < budget) begin
      step();
      n++;
    end
    checkOutput(name, 64'(expQ0.size() + expQ1.size()), 64'd0);
    step();
    step();
  endtask

  // Monitor: every forwarded flit must match the head of its VC's expected queue
  initial begin : monitor
    logic [FLIT_W-1:0] e;
    logic              eVc;
    bit                haveExp;
    forever begin
      @(negedge clk);
      if (monEn) begin
        if (o_credit_valid && o_credit_vc == 1'b1) credits1++;
        if (o_flit_valid) begin
          haveExp = 1'b0;
          e       = '0;
          eVc     = 1'b0;
          if (o_flit_vc == 1'b0 && expQ0.size() != 0) begin
            e = expQ0.pop_front(); eVc = 1'b0; haveExp = 1'b1;
          end else if (o_flit_vc == 1'b1 && expQ1.size() != 0) begin
            e = expQ1.pop_front(); eVc = 1'b1; haveExp = 1'b1;
          end
          if (haveExp) begin
            checkOutput("sb flit data", 64'(o_flit), 64'(e));
            checkOutput("sb credit", 64'({o_credit_valid, o_credit_vc}), 64'({1'b1, eVc}));
          end else begin
            checks++;
            failures++;
            $display("[TB] FAIL sb unexpected flit: got 0x%0h vc %0d expected none", o_flit, o_flit_vc);
          end
        end else if (o_credit_valid) begin
          checks++;
          failures++;
          $display("[TB] FAIL sb stray credit: got vc %0d expected no credit", o_credit_vc);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin : mainSeq
    logic [FLIT_W-1:0] tblFlit [6];
    logic              tblVc   [6];
    int                cred0;

    reset = 1'b1;
    idleLink();
    i_vc_ack     = '0;
    i_switch_ack = '0;
    repeat (3) step();
    checkOutput("reset flit/credit", 64'({o_flit_valid, o_credit_valid, o_credit_vc, o_flit_vc}), 64'd0);
    checkOutput("reset reqs/route", 64'({o_vc_req, o_switch_req, o_route, o_error}), 64'd0);
    checkOutput("reset flit", 64'(o_flit), 64'd0);
    reset = 1'b0;
    monEn = 1'b1;
    step();

    // Single HEAD_TAIL to ourselves on VC0 with immediate acks
    $display("[TB] test 1: HEAD_TAIL local");
    i_vc_ack     = 2'b11;
    i_switch_ack = 2'b01;
    applyStimulus(1'b0, mkFlit(HT, 24'hA00001, 4'd1, 4'd1), 1'b1);
    step(); idleLink();
    step();
    checkOutput("t1 routing route", 64'(o_route), 64'd0);
    checkOutput("t1 routing vc_req", 64'(o_vc_req), 64'd0);
    step();
    checkOutput("t1 waiting vc_req", 64'(o_vc_req), 64'b01);
    checkOutput("t1 route local", 64'(o_route), 64'b00000_00001);
    step();
    checkOutput("t1 active switch_req", 64'(o_switch_req), 64'b01);
    checkOutput("t1 active vc_req", 64'(o_vc_req), 64'd0);
    step();
    checkOutput("t1 flit_valid t+5", 64'(o_flit_valid), 64'd1);
    checkOutput("t1 credit t+5", 64'({o_credit_valid, o_credit_vc}), 64'b10);
    checkOutput("t1 back idle route", 64'(o_route), 64'd0);
    step();
    checkOutput("t1 quiet after", 64'({o_flit_valid, o_switch_req, o_vc_req}), 64'd0);

    // Four-flit packet on VC1 heading east with acks held high
    $display("[TB] test 2: 4-flit packet east");
    cred0        = credits1;
    i_switch_ack = 2'b10;
    applyStimulus(1'b1, mkFlit(HEAD, 24'hB00000, 4'd3, 4'd0), 1'b1); step();
    applyStimulus(1'b1, mkFlit(BODY, 24'hB00001, 4'd0, 4'd0), 1'b1); step();
    applyStimulus(1'b1, mkFlit(BODY, 24'hB00002, 4'd0, 4'd0), 1'b1); step();
    applyStimulus(1'b1, mkFlit(TAIL, 24'hB00003, 4'd0, 4'd0), 1'b1); step();
    idleLink();
    checkOutput("t2 route east", 64'(o_route), 64'b00100_00000);
    checkOutput("t2 switch_req", 64'(o_switch_req), 64'b10);
    step();
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("t2 flit %0d valid/vc", k), 64'({o_flit_valid, o_flit_vc}), 64'b11);
      step();
    end
    checkOutput("t2 idle after tail", 64'({o_flit_valid, o_route}), 64'd0);
    checkOutput("t2 credits vc1", 64'(credits1 - cred0), 64'd4);

    // Interleaved packets on both VCs with alternating switch grants
    $display("[TB] test 3: interleaved VCs");
    tblFlit[0] = mkFlit(HEAD, 24'hC00000, 4'd0, 4'd1); tblVc[0] = 1'b0;
    tblFlit[1] = mkFlit(HEAD, 24'hD00000, 4'd1, 4'd2); tblVc[1] = 1'b1;
    tblFlit[2] = mkFlit(BODY, 24'hC00001, 4'd0, 4'd0); tblVc[2] = 1'b0;
    tblFlit[3] = mkFlit(BODY, 24'hD00001, 4'd0, 4'd0); tblVc[3] = 1'b1;
    tblFlit[4] = mkFlit(TAIL, 24'hC00002, 4'd0, 4'd0); tblVc[4] = 1'b0;
    tblFlit[5] = mkFlit(TAIL, 24'hD00002, 4'd0, 4'd0); tblVc[5] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 5) checkOutput("t3 routes north/west", 64'(o_route), 64'b00010_10000);
      if (c < 6) applyStimulus(tblVc[c], tblFlit[c], 1'b1);
      else       idleLink();
      i_switch_ack = c[0] ? 2'b10 : 2'b01;
      step();
    end
    i_switch_ack = 2'b00;
    waitDrain("t3 drained", 20);

    // VC allocation withheld for ten cycles
    $display("[TB] test 4: vc_ack held low");
    i_vc_ack     = 2'b00;
    i_switch_ack = 2'b01;
    applyStimulus(1'b0, mkFlit(HT, 24'hE00000, 4'd1, 4'd0), 1'b1);
    step(); idleLink();
    step(); step();
    checkOutput("t4 route south", 64'(o_route), 64'b00000_01000);
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("t4 wait %0d vc_req", k), 64'(o_vc_req), 64'b01);
      checkOutput($sformatf("t4 wait %0d switch_req", k), 64'(o_switch_req), 64'd0);
      step();
    end
    i_vc_ack = 2'b01;
    step();
    checkOutput("t4 active switch_req", 64'(o_switch_req), 64'b01);
    checkOutput("t4 active vc_req", 64'(o_vc_req), 64'd0);
    step();
    checkOutput("t4 flit out", 64'({o_flit_valid, o_flit_vc}), 64'b10);
    waitDrain("t4 drained", 10);

    // Overflow on a full VC, then push-while-pop on the full VC
    $display("[TB] test 5: overflow");
    i_vc_ack     = 2'b00;
    i_switch_ack = 2'b00;
    applyStimulus(1'b0, mkFlit(HEAD, 24'hF00000, 4'd2, 4'd1), 1'b1); step();
    applyStimulus(1'b0, mkFlit(BODY, 24'hF00001, 4'd0, 4'd0), 1'b1); step();
    applyStimulus(1'b0, mkFlit(BODY, 24'hF00002, 4'd0, 4'd0), 1'b1); step();
    applyStimulus(1'b0, mkFlit(BODY, 24'hF00003, 4'd0, 4'd0), 1'b1); step();
    applyStimulus(1'b0, mkFlit(BODY, 24'hF000FF, 4'd0, 4'd0), 1'b0); step();
    idleLink();
    checkOutput("t5 error after overflow", 64'(o_error), 64'(EXP_ERR));
    checkOutput("t5 route east", 64'(o_route), 64'b00000_00100);
    i_vc_ack = 2'b01;
    step();
    checkOutput("t5 full switch_req", 64'(o_switch_req), 64'b01);
    i_switch_ack = 2'b01;
    applyStimulus(1'b0, mkFlit(TAIL, 24'hF00004, 4'd0, 4'd0), 1'b1);
    step(); idleLink();
    waitDrain("t5 drained", 20);
    checkOutput("t5 idle after tail", 64'({o_route, o_vc_req, o_switch_req}), 64'd0);

    // Reset with two flits buffered on VC1
    $display("[TB] test 6: reset mid-packet");
    i_vc_ack     = 2'b00;
    i_switch_ack = 2'b00;
    applyStimulus(1'b1, mkFlit(HEAD, 24'h900000, 4'd1, 4'd1), 1'b0); step();
    applyStimulus(1'b1, mkFlit(BODY, 24'h900001, 4'd0, 4'd0), 1'b0); step();
    idleLink(); step();
    checkOutput("t6 waiting before reset", 64'(o_vc_req), 64'b10);
    reset        = 1'b1;
    i_vc_ack     = 2'b10;
    i_switch_ack = 2'b10;
    step();
    checkOutput("t6 reset reqs/route", 64'({o_vc_req, o_switch_req, o_route, o_error}), 64'd0);
    checkOutput("t6 reset flit/credit", 64'({o_flit_valid, o_credit_valid, o_credit_vc, o_flit_vc}), 64'd0);
    checkOutput("t6 reset flit", 64'(o_flit), 64'd0);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      checkOutput($sformatf("t6 empty after reset %0d", k),
                  64'({o_vc_req, o_switch_req, o_flit_valid, o_credit_valid}), 64'd0);
    end
    applyStimulus(1'b1, mkFlit(HT, 24'h910000, 4'd1, 4'd1), 1'b1);
    step(); idleLink();
    waitDrain("t6 fresh packet drained", 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
